// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: decode-side input and immediate-side output.
// The illegal field exists only when IMM_GEN_ILLEGAL_EN is defined.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      ins;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic [2:0]       fmt;
  logic [TAG_W-1:0] out_tag;
`ifdef IMM_GEN_ILLEGAL_EN
  logic             illegal;

  modport master (output in_valid, ins, in_tag, out_ready,
                  input  in_ready, out_valid, imm, fmt, out_tag, illegal);
  modport slave  (input  in_valid, ins, in_tag, out_ready,
                  output in_ready, out_valid, imm, fmt, out_tag, illegal);
`else
  modport master (output in_valid, ins, in_tag, out_ready,
                  input  in_ready, out_valid, imm, fmt, out_tag);
  modport slave  (input  in_valid, ins, in_tag, out_ready,
                  output in_ready, out_valid, imm, fmt, out_tag);
`endif
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator (I/S/B/U/J) behind a 2-entry skid buffer.
// Optional macro IMM_GEN_ILLEGAL_EN adds a registered illegal-encoding flag.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  imm_gen_pipe_if.slave bus
);
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  function automatic logic [2:0] dec_fmt(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b0011011,
      7'b1100111, 7'b1110011: dec_fmt = FMT_I;
      7'b0100011:             dec_fmt = FMT_S;
      7'b1100011:             dec_fmt = FMT_B;
      7'b0110111, 7'b0010111: dec_fmt = FMT_U;
      7'b1101111:             dec_fmt = FMT_J;
      default:                dec_fmt = FMT_NONE;
    endcase
  endfunction

  // Build the 32-bit signed immediate, then sign-extend through a signed cast.
  function automatic logic signed [XLEN-1:0] dec_imm(input logic [31:0] ins,
                                                     input logic [2:0]  f);
    logic signed [31:0] imm32;
    case (f)
      FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm32 = {ins[31:12], 12'b0};
      FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    return XLEN'(imm32);
  endfunction

  logic [2:0]              raw_fmt;
  logic [2:0]              dec_fmt_w;
  logic signed [XLEN-1:0]  dec_imm_w;
  logic                    dec_ill_w;

  assign raw_fmt = dec_fmt(bus.ins[6:0]);
`ifdef IMM_GEN_ILLEGAL_EN
  assign dec_ill_w = (raw_fmt == FMT_NONE) || (bus.ins[1:0] != 2'b11);
`else
  assign dec_ill_w = 1'b0;
`endif
  assign dec_fmt_w = dec_ill_w ? FMT_NONE : raw_fmt;
  assign dec_imm_w = dec_imm(bus.ins, dec_fmt_w);

  logic                   o_vld_q, o_vld_d, k_vld_q, k_vld_d;
  logic signed [XLEN-1:0] o_imm_q, o_imm_d, k_imm_q, k_imm_d;
  logic [2:0]             o_fmt_q, o_fmt_d, k_fmt_q, k_fmt_d;
  logic [TAG_W-1:0]       o_tag_q, o_tag_d, k_tag_q, k_tag_d;
  logic                   o_ill_q, o_ill_d, k_ill_q, k_ill_d;
  logic                   acc, xfer;

  assign acc  = bus.in_valid && !k_vld_q;
  assign xfer = o_vld_q && bus.out_ready;

  // Priority: flush, drain skid, load output, park in skid, retire output.
  always_comb begin
    o_vld_d = o_vld_q;  o_imm_d = o_imm_q;  o_fmt_d = o_fmt_q;
    o_tag_d = o_tag_q;  o_ill_d = o_ill_q;
    k_vld_d = k_vld_q;  k_imm_d = k_imm_q;  k_fmt_d = k_fmt_q;
    k_tag_d = k_tag_q;  k_ill_d = k_ill_q;
    if (flush) begin
      o_vld_d = 1'b0;
      k_vld_d = 1'b0;
    end else if (k_vld_q && xfer) begin
      o_imm_d = k_imm_q;  o_fmt_d = k_fmt_q;
      o_tag_d = k_tag_q;  o_ill_d = k_ill_q;
      k_vld_d = 1'b0;
    end else if (acc && (!o_vld_q || xfer)) begin
      o_vld_d = 1'b1;       o_imm_d = dec_imm_w;  o_fmt_d = dec_fmt_w;
      o_tag_d = bus.in_tag; o_ill_d = dec_ill_w;
    end else if (acc) begin
      k_vld_d = 1'b1;       k_imm_d = dec_imm_w;  k_fmt_d = dec_fmt_w;
      k_tag_d = bus.in_tag; k_ill_d = dec_ill_w;
    end else if (xfer) begin
      o_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_vld_q <= 1'b0;
      k_vld_q <= 1'b0;
      o_imm_q <= '0;
      o_fmt_q <= '0;
      o_tag_q <= '0;
      o_ill_q <= 1'b0;
    end else begin
      o_vld_q <= o_vld_d;
      k_vld_q <= k_vld_d;
      o_imm_q <= o_imm_d;
      o_fmt_q <= o_fmt_d;
      o_tag_q <= o_tag_d;
      o_ill_q <= o_ill_d;
    end
  end

  // Skid payload is only meaningful while k_vld_q is set.
  always_ff @(posedge clk) begin
    k_imm_q <= k_imm_d;
    k_fmt_q <= k_fmt_d;
    k_tag_q <= k_tag_d;
    k_ill_q <= k_ill_d;
  end

  assign bus.in_ready  = !k_vld_q;
  assign bus.out_valid = o_vld_q;
  assign bus.imm       = o_imm_q;
  assign bus.fmt       = o_fmt_q;
  assign bus.out_tag   = o_tag_q;
`ifdef IMM_GEN_ILLEGAL_EN
  assign bus.illegal   = o_ill_q;
`else
  logic unused_ill;
  assign unused_ill = o_ill_q ^ dec_ill_w;
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed vectors, queue-based monitor.
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic reset, flush;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus ();
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus.slave)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_xfer = 0;
  logic [63:0] cur_imm;
  logic [2:0]  cur_fmt;
  logic        cur_ill;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: pop on every transfer, push on every accepted input.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_xfer++;
        chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
          chk("out_fmt", 64'(bus.fmt), 64'(e.fmt));
          chk("out_imm", bus.imm, e.imm);
`ifdef IMM_GEN_ILLEGAL_EN
          chk("out_illegal", 64'(bus.illegal), 64'(e.ill));
`endif
        end
      end
      if (flush) sb.delete();
      else if (bus.in_valid && bus.in_ready)
        sb.push_back('{imm: cur_imm, fmt: cur_fmt, tag: bus.in_tag, ill: cur_ill});
    end
  end

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] t,
                       input logic [63:0] ei, input logic [2:0] ef, input logic rdy);
    @(posedge clk); #1;
    bus.in_valid  = v;
    bus.ins       = i;
    bus.in_tag    = t;
    bus.out_ready = rdy;
    cur_imm       = ei;
    cur_fmt       = ef;
    cur_ill       = (ef == 3'd0);
  endtask

  logic [31:0] v_ins [8];
  logic [63:0] v_imm [8];
  logic [2:0]  v_fmt [8];
  int          xfer0;

  initial begin
    v_ins[0] = 32'hFFF00093; v_imm[0] = 64'hFFFFFFFFFFFFFFFF; v_fmt[0] = 3'd1;
    v_ins[1] = 32'hFE112E23; v_imm[1] = 64'hFFFFFFFFFFFFFFFC; v_fmt[1] = 3'd2;
    v_ins[2] = 32'hFE000CE3; v_imm[2] = 64'hFFFFFFFFFFFFFFF8; v_fmt[2] = 3'd3;
    v_ins[3] = 32'h123450B7; v_imm[3] = 64'h0000000012345000; v_fmt[3] = 3'd4;
    v_ins[4] = 32'h0000006F; v_imm[4] = 64'h0000000000000000; v_fmt[4] = 3'd5;
    v_ins[5] = 32'h00500093; v_imm[5] = 64'h0000000000000005; v_fmt[5] = 3'd1;
    v_ins[6] = 32'h80000037; v_imm[6] = 64'hFFFFFFFF80000000; v_fmt[6] = 3'd4;
    v_ins[7] = 32'h00000001; v_imm[7] = 64'h0000000000000000; v_fmt[7] = 3'd0;

    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.ins = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    cur_imm = '0; cur_fmt = '0; cur_ill = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_imm", bus.imm, 64'd0);
    chk("rst_fmt", 64'(bus.fmt), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1 reset = 1'b0;

    // Back-to-back stream with out_ready high: one result per cycle.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, v_ins[k], 32'(k + 1), v_imm[k], v_fmt[k], 1'b1);
      @(negedge clk);
      chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
      if (k > 0) chk("stream_out_valid", 64'(bus.out_valid), 64'd1);
    end
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    @(negedge clk);
    chk("stream_last_valid", 64'(bus.out_valid), 64'd1);
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    @(negedge clk);
    chk("stream_drained", 64'(bus.out_valid), 64'd0);

    // Backpressure: tags 0x11, 0x12 accepted, 0x13 held off until drain.
    drive(1'b1, v_ins[1], 32'h11, v_imm[1], v_fmt[1], 1'b0);
    @(negedge clk); chk("bp_rdy_a", 64'(bus.in_ready), 64'd1);
    drive(1'b1, v_ins[2], 32'h12, v_imm[2], v_fmt[2], 1'b0);
    @(negedge clk); chk("bp_rdy_b", 64'(bus.in_ready), 64'd1);
    drive(1'b1, v_ins[3], 32'h13, v_imm[3], v_fmt[3], 1'b0);
    @(negedge clk);
    chk("bp_full_rdy", 64'(bus.in_ready), 64'd0);
    chk("bp_head_tag", 64'(bus.out_tag), 64'h11);
    drive(1'b1, v_ins[3], 32'h13, v_imm[3], v_fmt[3], 1'b0);
    @(negedge clk);
    chk("bp_hold_rdy", 64'(bus.in_ready), 64'd0);
    chk("bp_hold_tag", 64'(bus.out_tag), 64'h11);
    chk("bp_hold_imm", bus.imm, 64'hFFFFFFFFFFFFFFFC);
    xfer0 = n_xfer;
    drive(1'b1, v_ins[3], 32'h13, v_imm[3], v_fmt[3], 1'b1);
    @(negedge clk);
    chk("bp_rel_tag1", 64'(bus.out_tag), 64'h11);
    chk("bp_rel_rdy", 64'(bus.in_ready), 64'd0);
    drive(1'b1, v_ins[3], 32'h13, v_imm[3], v_fmt[3], 1'b1);
    @(negedge clk);
    chk("bp_rel_tag2", 64'(bus.out_tag), 64'h12);
    chk("bp_rel_rdy2", 64'(bus.in_ready), 64'd1);
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    @(negedge clk); chk("bp_rel_tag3", 64'(bus.out_tag), 64'h13);
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    @(negedge clk);
    chk("bp_empty", 64'(bus.out_valid), 64'd0);
    chk("bp_xfer_count", 64'(n_xfer - xfer0), 64'd3);

    // Flush with both registers full and an entry on the input.
    drive(1'b1, v_ins[5], 32'h21, v_imm[5], v_fmt[5], 1'b0);
    drive(1'b1, v_ins[6], 32'h22, v_imm[6], v_fmt[6], 1'b0);
    drive(1'b1, v_ins[0], 32'h23, v_imm[0], v_fmt[0], 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_full_before", 64'(bus.in_ready), 64'd0);
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    flush = 1'b0;
    @(negedge clk);
    chk("fl_full_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_full_in_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    @(negedge clk); chk("fl_full_stays_empty", 64'(bus.out_valid), 64'd0);

    // Flush while an entry would otherwise be accepted into the skid.
    drive(1'b1, v_ins[5], 32'h31, v_imm[5], v_fmt[5], 1'b0);
    drive(1'b1, v_ins[6], 32'h32, v_imm[6], v_fmt[6], 1'b0);
    flush = 1'b1;
    @(negedge clk);
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    flush = 1'b0;
    @(negedge clk);
    chk("fl_acc_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_acc_in_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b1, v_ins[1], 32'h33, v_imm[1], v_fmt[1], 1'b1);
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    @(negedge clk); chk("fl_recover_valid", 64'(bus.out_valid), 64'd1);

    // Reset mid-stream with the skid full.
    drive(1'b1, v_ins[2], 32'h41, v_imm[2], v_fmt[2], 1'b0);
    drive(1'b1, v_ins[3], 32'h42, v_imm[3], v_fmt[3], 1'b0);
    drive(1'b1, v_ins[0], 32'h43, v_imm[0], v_fmt[0], 1'b0);
    reset = 1'b1;
    @(negedge clk);
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_imm", bus.imm, 64'd0);
    chk("mrst_fmt", 64'(bus.fmt), 64'd0);
    chk("mrst_tag", 64'(bus.out_tag), 64'd0);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef IMM_GEN_ILLEGAL_EN
    chk("mrst_illegal", 64'(bus.illegal), 64'd0);
    drive(1'b1, 32'h00000001, 32'h51, 64'd0, 3'd0, 1'b0);
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    chk("ill_flag", 64'(bus.illegal), 64'd1);
    chk("ill_imm", bus.imm, 64'd0);
    drive(1'b0, '0, '0, '0, '0, 1'b1);
`endif
    repeat (3) drive(1'b0, '0, '0, '0, '0, 1'b1);
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the RV decode stage.
- Decodes the immediate format from the opcode and covers all base formats: I, S, B, U and J.
- Sign-extends the immediate to XLEN.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so decode can stall or flush without losing or duplicating instructions.

Parameters:
- XLEN, 64, output immediate width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (e.g. PC) carried alongside each instruction.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards all held entries.
- in_valid  input  1  ins/in_tag valid.
- in_ready  output  1  block can accept an entry this cycle.
- ins  input  32  raw instruction word.
- in_tag  input  TAG_W  sideband passed through unchanged.
- out_valid  output  1  imm/fmt/out_tag valid.
- out_ready  input  1  downstream accepts this cycle.
- imm  output  XLEN  sign-extended immediate.
- fmt  output  3  format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- out_tag  output  TAG_W  tag of the entry on imm.

Behaviour:
- Format decode on ins[6:0]:
  - I: 0000011, 0010011, 0011011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode: fmt 0, imm 0.
- Immediate construction; sign bit is always ins[31], replicated up to XLEN-1:
  - I: ins[31:20].
  - S: {ins[31:25], ins[11:7]}.
  - B: {ins[31], ins[7], ins[30:25], ins[11:8], 0}.
  - U: {ins[31:12], 12'b0}.
  - J: {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
- Storage: output register (O) plus skid register (K), each holding valid, imm, fmt and tag.
- Handshake:
  - in_ready = !K.valid, registered. It depends only on state, never combinationally on out_ready.
  - Accept = in_valid && in_ready. Latency from accept to out_valid is exactly 1 cycle.
  - Transfer = out_valid && out_ready.
- Next-state rules, in priority order:
  - reset: O.valid=0, K.valid=0, imm=0, fmt=0, out_tag=0; in_ready=1 in the cycle after reset.
  - flush (reset low): O.valid=0 and K.valid=0. Any entry accepted in the same cycle is dropped. Data fields hold their values.
  - K valid and transfer: O<=K, K.valid<=0.
  - Accept with O empty, or with transfer and K empty: O<=decoded input.
  - Accept while O valid and no transfer: K<=decoded input.
  - Transfer with no accept and K empty: O.valid<=0.
- Ordering: strict FIFO; the entry in K always follows the entry in O.
- Holding: while out_valid=1 and out_ready=0, imm, fmt and out_tag stay stable.
- Throughput: 1 entry per cycle with out_ready held high.
- Full condition: O and K both valid, so in_ready=0. The entry on the input is not sampled.
- Reset mid-operation: held entries are lost; no partial outputs.
- XLEN=32: the upper-extension logic vanishes and results are truncated to 32 bits.

Optional Feature:
- Macro: IMM_GEN_ILLEGAL_EN.
- When defined:
  - Adds output port illegal (1 bit), registered and skid-buffered with its entry.
  - illegal=1 when the opcode is not in the decode list, or when ins[1:0] != 2'b11 (compressed or invalid encoding).
  - When illegal=1, imm=0 and fmt=0.
  - Reset value of illegal is 0.
- When undefined: no illegal port; unknown opcodes produce fmt 0 and imm 0 silently.

Test Plan:
- Reset, then accept ins=0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle out_valid=1, fmt=1, imm=0xFFFFFFFFFFFFFFFF.
- ins=0xFE112E23 (sw x1,-4(x2)), then ins=0xFE000CE3 (beq x0,x0,-8) back-to-back -> fmt 2, imm=0xFFFFFFFFFFFFFFFC, then fmt 3, imm=0xFFFFFFFFFFFFFFF8, on consecutive cycles.
- ins=0x123450B7 (lui x1,0x12345) -> fmt 4, imm=0x0000000012345000. ins=0x0000006F (jal x0,0) -> fmt 5, imm=0.
- Backpressure: hold out_ready=0 and present tags 1, 2, 3 on consecutive cycles -> tags 1 and 2 accepted; in_ready=0 from the cycle after tag 2 is accepted; tag 3 held off. Then set out_ready=1 -> outputs tag 1, 2, 3 in order with no duplicates.
- Both registers full, assert flush for 1 cycle together with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed-cycle entry never appears at the output.
- Assert reset mid-stream with K full -> next cycle out_valid=0, imm=0, fmt=0, in_ready=1. If IMM_GEN_ILLEGAL_EN is defined: ins=0x00000001 -> illegal=1, imm=0.
